// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: IDLE/RUN/HALT FSM, 1-cycle registered outputs, no backpressure beyond i_stall/i_halt.
// Misaligned redirects trap to TRAP_VECTOR; define PC_SEQ_PERF_CNT_EN to build the advance/stall counters.
module pc_sequencer #(
  parameter int unsigned                ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]      RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0]      TRAP_VECTOR  = ADDR_WIDTH'(4),
  parameter int unsigned                INSN_BYTES   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_halt,
  input  logic                  i_stall,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_pc_valid,
  output logic [1:0]            o_state,
  output logic                  o_fault,
  output logic [ADDR_WIDTH-1:0] o_fault_addr,
  output logic [31:0]           o_adv_cnt,
  output logic [31:0]           o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_BAD  = 2'b11
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(INSN_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSN_BYTES - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pc_valid_q, pc_valid_d;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic                  redirect_aligned;

  assign redirect_aligned = ((i_redirect_pc & ALIGN_MASK) == '0);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_halt) begin
          state_d = ST_HALT;
        end else if (i_redirect_valid) begin
          if (redirect_aligned) begin
            pc_d = i_redirect_pc;
          end else begin
            pc_d         = TRAP_VECTOR;
            fault_d      = 1'b1;
            fault_addr_d = i_redirect_pc;
          end
        end else if (!i_stall) begin
          pc_d = pc_q + PC_INC;
        end
      end
      ST_HALT: begin
        // Halt wins over a simultaneous start; resume keeps the held PC.
        if (i_start && !i_halt) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    pc_valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_VECTOR;
      pc_valid_q   <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign o_pc         = pc_q;
  assign o_pc_valid   = pc_valid_q;
  assign o_state      = state_q;
  assign o_fault      = fault_q;
  assign o_fault_addr = fault_addr_q;

`ifdef PC_SEQ_PERF_CNT_EN
  logic        run_active;
  logic        adv_evt, stall_evt;
  logic [31:0] adv_cnt_q, adv_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign run_active = (state_q == ST_RUN) && !i_halt;
  // Trapped redirects still move the PC, so they count as advances.
  assign adv_evt    = run_active && (i_redirect_valid || !i_stall);
  assign stall_evt  = run_active && !i_redirect_valid && i_stall;

  always_comb begin
    adv_cnt_d   = adv_cnt_q + {31'd0, adv_evt};
    stall_cnt_d = stall_cnt_q + {31'd0, stall_evt};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      adv_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      adv_cnt_q   <= adv_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_adv_cnt   = adv_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_adv_cnt   = '0;
  assign o_stall_cnt = '0;
`endif

endmodule
